// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL quarter-phase generator.
package i2c_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_LOW1  = 2'd1;
  localparam logic [1:0] PH_HIGH0 = 2'd2;
  localparam logic [1:0] PH_HIGH1 = 2'd3;

  localparam logic SCL_RELEASED = 1'b1;

  // SCL is pulled low for the first half of the period, released for the second.
  function automatic logic scl_level(input logic [1:0] ph);
    return (ph == PH_HIGH0 || ph == PH_HIGH1) ? SCL_RELEASED : ~SCL_RELEASED;
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchroniser for the sensed SCL line; flops reset to the released level.
module i2c_sync
  import i2c_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= SCL_RELEASED;
          else     sync_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= SCL_RELEASED;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/i2c_phase_gen.sv
// I2C SCL generator: four quarters of div_cnt+1 clocks each, with graceful stop.
// Optional slave clock stretching in the first high quarter via macro I2C_CLK_STRETCH_EN.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_cnt,
  input  logic             scl_in,
  output logic             scl_out,
  output logic [1:0]       phase,
  output logic             phase_tick,
  output logic             busy,
  output logic             stretch
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg;
  logic [1:0]       phase_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_lat_reg;
  logic             scl_reg;
  logic             tick_reg;
  logic             hold;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_sync;

  i2c_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (scl_in),
    .q  (scl_sync)
  );

  // A slave holding SCL low freezes the counter at the start of the first high quarter.
  assign hold = (state_reg == RUN) && (phase_reg == PH_HIGH0) &&
                (cnt_reg == '0) && (scl_sync != SCL_RELEASED);
`else
  logic            unused_scl_in;
  localparam int   unused_sync_stages = SYNC_STAGES;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= PH_HIGH1;
      cnt_reg     <= '0;
      div_lat_reg <= '0;
      scl_reg     <= SCL_RELEASED;
      tick_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tick_reg <= 1'b0;
          if (en) begin
            state_reg   <= RUN;
            phase_reg   <= PH_LOW0;
            cnt_reg     <= '0;
            div_lat_reg <= div_cnt;
            scl_reg     <= scl_level(PH_LOW0);
            tick_reg    <= 1'b1;
          end
        end
        RUN: begin
          if (hold) begin
            tick_reg <= 1'b0;
          end else if (cnt_reg == div_lat_reg) begin
            cnt_reg <= '0;
            // Only the wrap out of the last quarter may stop, so periods are never cut short.
            if (phase_reg == PH_HIGH1 && !en) begin
              state_reg <= IDLE;
              phase_reg <= PH_HIGH1;
              scl_reg   <= SCL_RELEASED;
              tick_reg  <= 1'b0;
            end else begin
              phase_reg   <= phase_reg + 2'd1;
              scl_reg     <= scl_level(phase_reg + 2'd1);
              div_lat_reg <= div_cnt;
              tick_reg    <= 1'b1;
            end
          end else begin
            cnt_reg  <= cnt_reg + CNT_ONE;
            tick_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          tick_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign scl_out    = scl_reg;
  assign phase      = phase_reg;
  assign phase_tick = tick_reg;
  assign busy       = (state_reg == RUN);
  assign stretch    = hold;

endmodule

// File: tb/tb_i2c_phase_gen.sv
// Scoreboard bench for i2c_phase_gen: expected quarter ticks are queued, a monitor checks them.
module tb_i2c_phase_gen;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_cnt = '0;
  logic             scl_in = 1'b1;
  logic             scl_out;
  logic [1:0]       phase;
  logic             phase_tick;
  logic             busy;
  logic             stretch;

  i2c_phase_gen #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_cnt   (div_cnt),
    .scl_in    (scl_in),
    .scl_out   (scl_out),
    .phase     (phase),
    .phase_tick(phase_tick),
    .busy      (busy),
    .stretch   (stretch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int gap;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tick = 0;
  bit watch_stretch = 1'b0;
  int stretch_seen = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int ph, input int gap);
    tick_exp_t e;
    e.ph  = ph;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_scl"}, scl_out, 1);
    check({name, "_phase"}, phase, 3);
    check({name, "_stretch"}, stretch, 0);
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check({name, "_idle_reached"}, seen, 1);
    check_idle(name);
  endtask

  task automatic check_drained(input string name);
    check({name, "_ticks_left"}, exp_q.size(), 0);
  endtask

  // Monitor: every phase_tick consumes one expected quarter start.
  always @(negedge clk) begin
    tick_exp_t e;
    cyc++;
    if (watch_stretch && stretch) stretch_seen++;
    if (phase_tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tick_phase", phase, e.ph);
        check("tick_scl", scl_out, (e.ph >= 2) ? 1 : 0);
        check("tick_busy", busy, 1);
        if (e.gap >= 0) check("tick_gap", cyc - last_tick, e.gap);
        $display("tick cyc=%0d phase=%0d scl=%0d gap=%0d exp_phase=%0d exp_gap=%0d",
                 cyc, phase, scl_out, cyc - last_tick, e.ph, e.gap);
      end
      last_tick = cyc;
    end
  end

  // Three full periods at div_cnt=3 with the stop requested during the last high quarter.
  task automatic run_three_periods(input logic scl_level_in, input bit watch);
    scl_in = scl_level_in;
    div_cnt = 16'd3;
    stretch_seen = 0;
    watch_stretch = watch;
    @(posedge clk); #1 en = 1'b1;
    push(0, -1); push(1, 4); push(2, 4); push(3, 4);
    for (int p = 0; p < 2; p++) for (int q = 0; q < 4; q++) push(q, 4);
    @(posedge clk);
    repeat (46) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk); check("p3_busy_a", busy, 1);
    @(negedge clk); check("p3_busy_b", busy, 1); check("p3_last_phase", phase, 3);
    @(negedge clk); check_idle("p3_end");
    watch_stretch = 1'b0;
    check("p3_stretch_seen", stretch_seen, 0);
    check_drained("p3");
    scl_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_cnt = 16'd3; scl_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_tick", phase_tick, 0);

    // Reset in the middle of a quarter.
    @(posedge clk); #1 en = 1'b1;
    push(0, -1); push(1, 4);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("midq_rst");
    check("midq_rst_tick", phase_tick, 0);
    @(posedge clk); #1 rst = 1'b0;
    check_drained("midq_rst");

    run_three_periods(1'b1, 1'b0);

    // div_cnt=0: one-cycle quarters, stop requested in phase 1.
    @(posedge clk); #1 div_cnt = 16'd0; en = 1'b1;
    push(0, -1); push(1, 1); push(2, 1); push(3, 1);
    push(0, 1); push(1, 1); push(2, 1); push(3, 1);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk); check("d0_ph1", phase, 1); check("d0_scl_low", scl_out, 0);
    @(negedge clk); check("d0_ph2", phase, 2); check("d0_scl_high", scl_out, 1);
    @(negedge clk); check("d0_ph3", phase, 3); check("d0_busy", busy, 1);
    @(negedge clk); check_idle("d0_end");
    check_drained("d0");

    // Mid-quarter divider change, then en dropped and restored before the wrap.
    @(posedge clk); #1 div_cnt = 16'd3; en = 1'b1;
    push(0, -1); push(1, 4); push(2, 8); push(3, 8);
    push(0, 8); push(1, 8); push(2, 8); push(3, 8);
    @(posedge clk);
    @(posedge clk); #1 div_cnt = 16'd7;
    repeat (12) @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    repeat (14) @(posedge clk);
    #1 en = 1'b0;
    wait_idle("divchg");
    check_drained("divchg");

`ifdef I2C_CLK_STRETCH_EN
    begin
      bit found;
      // Line held low through the low quarters and 10 cycles into phase 2.
      @(posedge clk); #1 div_cnt = 16'd3; scl_in = 1'b0; en = 1'b1;
      push(0, -1); push(1, 4); push(2, 4); push(3, 16);
      push(0, 4); push(1, 4); push(2, 4);
      push(0, -1); push(1, 4); push(2, 4); push(3, 4);
      @(posedge clk);
      repeat (8) @(posedge clk);
      @(negedge clk); check("st_start", stretch, 1); check("st_start_ph", phase, 2);
      repeat (10) @(posedge clk);
      #1 scl_in = 1'b1;
      @(negedge clk); check("st_hold_a", stretch, 1);
      @(negedge clk); check("st_hold_b", stretch, 1); check("st_no_retick", phase_tick, 0);
      @(negedge clk); check("st_release", stretch, 0); check("st_release_ph", phase, 2);
      repeat (4) @(posedge clk);
      #1 scl_in = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk);
        if (stretch) found = 1'b1;
      end
      check("st2_found", found, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; scl_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_idle("st_rst");
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("st_restart_busy", busy, 1); check("st_restart_ph", phase, 0);
      @(posedge clk); #1 en = 1'b0;
      wait_idle("st_end");
      check_drained("st");
    end
`else
    run_three_periods(1'b0, 1'b1);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
